// File: rtl/adcdecimate_pkg.sv
// Shared definitions for the ADC decimation/packing stage: register map,
// reduction modes and the byte-reduction helper.
package adcdecimate_pkg;

  localparam int SAMPLE_W_DEF = 72;

  localparam logic [15:0] ADDR_DIV  = 16'h0000;
  localparam logic [15:0] ADDR_MODE = 16'h0001;

  typedef enum logic [1:0] {
    MODE_PICK = 2'd0,
    MODE_MAX  = 2'd1,
    MODE_MIN  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Folds one new byte into the running group value; reserved mode behaves as pick.
  function automatic logic [7:0] reduce_byte(input mode_e mode,
                                             input logic [7:0] acc,
                                             input logic [7:0] din);
    logic [7:0] r;
    r = acc;
    case (mode)
      MODE_MAX: begin
        if (din > acc) r = din;
        else           r = acc;
      end
      MODE_MIN: begin
        if (din < acc) r = din;
        else           r = acc;
      end
      default: r = acc;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adcdecimate_decimreduce.sv
// Group reducer: collapses each run of DIV+1 ADC bytes into one byte.
// The reduced byte is combinational so the packer can register it directly.
module adcdecimate_decimreduce
  import adcdecimate_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] div_i,
  input  mode_e      mode_i,
  input  logic [7:0] din_i,
  output logic [7:0] red_o,
  output logic       red_vld_o
);

  logic [7:0] grp_cnt_q, grp_cnt_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] cur_s;

  // Next group count / accumulator and the end-of-group strobe
  always_comb begin
    grp_cnt_d = grp_cnt_q;
    acc_d     = acc_q;
    cur_s     = din_i;
    red_vld_o = 1'b0;
    if (clr_i || !en_i) begin
      grp_cnt_d = 8'd0;
      acc_d     = 8'd0;
    end else begin
      if (grp_cnt_q == 8'd0) begin
        cur_s = din_i;
      end else begin
        cur_s = reduce_byte(mode_i, acc_q, din_i);
      end
      acc_d = cur_s;
      if (grp_cnt_q >= div_i) begin
        red_vld_o = 1'b1;
        grp_cnt_d = 8'd0;
      end else begin
        grp_cnt_d = grp_cnt_q + 8'd1;
      end
    end
  end

  assign red_o = cur_s;

  // Group state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_cnt_q <= 8'd0;
      acc_q     <= 8'd0;
    end else begin
      grp_cnt_q <= grp_cnt_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: rtl/adcdecimate.sv
// Per-channel ADC decimation and packing stage with an 8-bit wishbone
// configuration slave (DIV, MODE).
module adcdecimate
  import adcdecimate_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          adc_data,
  input  logic                sq_active,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_avail,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [15:0]         wb_adr_i,
  input  logic [7:0]          wb_dat_i,
  output logic [7:0]          wb_dat_o,
  output logic                wb_ack_o
);

  localparam int BYTES  = SAMPLE_W / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES - 1);

  logic                ack_q, ack_d;
  logic [7:0]          dat_q, dat_d;
  logic [7:0]          div_q, div_d;
  logic [1:0]          mode_q, mode_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [SAMPLE_W-1:0] word_q, word_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                avail_q, avail_d;

  logic                access_s;
  logic                restart_s;
  logic [7:0]          red_s;
  logic                red_vld_s;
  logic [SAMPLE_W-1:0] word_ins_s;

  assign access_s  = wb_stb_i & wb_cyc_i & ~ack_q;
  assign restart_s = access_s & wb_we_i &
                     ((wb_adr_i == ADDR_DIV) | (wb_adr_i == ADDR_MODE));

  adcdecimate_decimreduce u_decimreduce (
    .clk       (clk),
    .rst       (rst),
    .en_i      (sq_active),
    .clr_i     (restart_s),
    .div_i     (div_q),
    .mode_i    (mode_e'(mode_q)),
    .din_i     (adc_data),
    .red_o     (red_s),
    .red_vld_o (red_vld_s)
  );

  // Wishbone register file: registers and read data commit on the edge that raises ack
  always_comb begin
    ack_d  = access_s;
    dat_d  = dat_q;
    div_d  = div_q;
    mode_d = mode_q;
    if (access_s) begin
      if (wb_we_i) begin
        dat_d = 8'h00;
        case (wb_adr_i)
          ADDR_DIV:  div_d  = wb_dat_i;
          ADDR_MODE: mode_d = wb_dat_i[1:0];
          default:   div_d  = div_q;
        endcase
      end else begin
        case (wb_adr_i)
          ADDR_DIV:  dat_d = div_q;
          ADDR_MODE: dat_d = {6'b000000, mode_q};
          default:   dat_d = 8'h00;
        endcase
      end
    end else begin
      dat_d = dat_q;
    end
  end

  // Packer: restart or capture stop drops the partial word, which is never emitted
  always_comb begin
    lane_d     = lane_q;
    word_d     = word_q;
    sample_d   = sample_q;
    avail_d    = 1'b0;
    word_ins_s = word_q;
    word_ins_s[{lane_q, 3'b000} +: 8] = red_s;
    if (restart_s || !sq_active) begin
      lane_d = {LANE_W{1'b0}};
      word_d = {SAMPLE_W{1'b0}};
    end else if (red_vld_s) begin
      if (lane_q == LANE_LAST) begin
        sample_d = word_ins_s;
        avail_d  = 1'b1;
        lane_d   = {LANE_W{1'b0}};
        word_d   = {SAMPLE_W{1'b0}};
      end else begin
        word_d = word_ins_s;
        lane_d = lane_q + LANE_W'(1);
      end
    end else begin
      lane_d = lane_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      dat_q    <= 8'h00;
      div_q    <= 8'h00;
      mode_q   <= 2'b00;
      lane_q   <= {LANE_W{1'b0}};
      word_q   <= {SAMPLE_W{1'b0}};
      sample_q <= {SAMPLE_W{1'b0}};
      avail_q  <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      div_q    <= div_d;
      mode_q   <= mode_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
      sample_q <= sample_d;
      avail_q  <= avail_d;
    end
  end

  assign sample       = sample_q;
  assign sample_avail = avail_q;
  assign wb_dat_o     = dat_q;
  assign wb_ack_o     = ack_q;

endmodule

// File: tb/tb_adcdecimate.sv
// Self-checking bench for adcdecimate: directed scenarios plus a randomized run,
// all compared against a queue-based reference of groups and words.
module tb_adcdecimate;

  localparam int SW    = 72;
  localparam int BYTES = SW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    adc_data;
  logic          sq_active;
  logic [SW-1:0] sample;
  logic          sample_avail;
  logic          wb_stb_i, wb_cyc_i, wb_we_i;
  logic [15:0]   wb_adr_i;
  logic [7:0]    wb_dat_i, wb_dat_o;
  logic          wb_ack_o;

  adcdecimate #(.SAMPLE_W(SW)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .sq_active(sq_active),
    .sample(sample), .sample_avail(sample_avail),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference state
  logic [7:0]    m_div;
  logic [1:0]    m_mode;
  logic [7:0]    grp[$];
  logic [7:0]    wq[$];
  logic [SW-1:0] e_sample;
  logic          e_avail, e_ack, e_rd;
  logic [7:0]    e_dat;

  int            gen_kind;
  logic [7:0]    ramp_v;
  int            rep_i;
  logic [7:0]    rep_pat [4] = '{8'h10, 8'h80, 8'h20, 8'h05};

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_reduce(input logic [1:0] mode, input logic [7:0] g[$]);
    logic [7:0] r;
    r = g[0];
    foreach (g[i]) begin
      if (mode == 2'd1 && g[i] > r) r = g[i];
      if (mode == 2'd2 && g[i] < r) r = g[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_div = 8'h00; m_mode = 2'd0;
    grp.delete(); wq.delete();
    e_sample = '0; e_avail = 1'b0; e_ack = 1'b0; e_rd = 1'b0; e_dat = 8'h00;
  endtask

  task automatic model_step();
    logic          acc, wr_cfg;
    logic [SW-1:0] w;
    acc    = wb_stb_i && wb_cyc_i && !e_ack;
    wr_cfg = acc && wb_we_i && (wb_adr_i == 16'h0000 || wb_adr_i == 16'h0001);
    e_rd   = acc && !wb_we_i;
    if (e_rd)
      e_dat = (wb_adr_i == 16'h0000) ? m_div :
              (wb_adr_i == 16'h0001) ? {6'b000000, m_mode} : 8'h00;
    e_avail = 1'b0;
    if (wr_cfg || !sq_active) begin
      grp.delete(); wq.delete();
    end else begin
      grp.push_back(adc_data);
      if (grp.size() == int'(m_div) + 1) begin
        wq.push_back(ref_reduce(m_mode, grp));
        grp.delete();
        if (wq.size() == BYTES) begin
          w = '0;
          foreach (wq[i]) w[8*i +: 8] = wq[i];
          e_sample = w;
          e_avail  = 1'b1;
          wq.delete();
        end
      end
    end
    if (wr_cfg) begin
      if (wb_adr_i == 16'h0000) m_div = wb_dat_i;
      else                      m_mode = wb_dat_i[1:0];
    end
    e_ack = acc;
  endtask

  task automatic tick();
    case (gen_kind)
      0: begin adc_data = ramp_v; ramp_v = ramp_v + 8'd1; end
      1: begin adc_data = rep_pat[rep_i]; rep_i = (rep_i + 1) % 4; end
      default: adc_data = 8'($urandom);
    endcase
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("avail", SW'(sample_avail), SW'(e_avail));
    check("sample", sample, e_sample);
    check("ack", SW'(wb_ack_o), SW'(e_ack));
    if (e_rd) check("rdata", SW'(wb_dat_o), SW'(e_dat));
  endtask

  task automatic wb_access(input logic we, input logic [15:0] adr, input logic [7:0] dat,
                           output logic [7:0] rd);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    tick();
    rd = wb_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0]    rd;
    logic [7:0]    first;
    logic [SW-1:0] exp_w;
    logic [SW-1:0] k_word;
    int            n;

    rst = 1'b1; adc_data = 8'h00; sq_active = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 16'h0000; wb_dat_i = 8'h00;
    gen_kind = 0; ramp_v = 8'h00; rep_i = 0;
    model_reset();
    #1;
    check("rst_sample", sample, '0);
    check("rst_avail", SW'(sample_avail), '0);
    check("rst_ack", SW'(wb_ack_o), '0);
    check("rst_dat", SW'(wb_dat_o), '0);
    @(negedge clk);
    rst = 1'b0;

    // DIV=0 pick on a ramp
    gen_kind = 0; ramp_v = 8'h00; sq_active = 1'b1;
    repeat (9) tick();
    k_word = 72'h080706050403020100;
    check("ramp_w0", sample, k_word);
    check("ramp_w0_avail", SW'(sample_avail), SW'(1'b1));
    repeat (9) tick();
    k_word = 72'h11100f0e0d0c0b0a09;
    check("ramp_w1", sample, k_word);
    sq_active = 1'b0;
    tick();

    // DIV=3 with max, min and reserved mode on a repeating pattern
    wb_access(1'b1, 16'h0000, 8'h03, rd);
    wb_access(1'b1, 16'h0001, 8'h01, rd);
    gen_kind = 1; rep_i = 0; sq_active = 1'b1;
    repeat (36) tick();
    k_word = 72'h808080808080808080;
    check("max_word", sample, k_word);
    check("max_avail", SW'(sample_avail), SW'(1'b1));
    sq_active = 1'b0;
    wb_access(1'b1, 16'h0001, 8'h02, rd);
    rep_i = 0; sq_active = 1'b1;
    repeat (36) tick();
    k_word = 72'h050505050505050505;
    check("min_word", sample, k_word);
    sq_active = 1'b0;
    wb_access(1'b1, 16'h0001, 8'h03, rd);
    rep_i = 0; sq_active = 1'b1;
    repeat (36) tick();
    k_word = 72'h101010101010101010;
    check("mode3_word", sample, k_word);
    sq_active = 1'b0;

    // capture dropped mid-word, then resumed
    wb_access(1'b1, 16'h0000, 8'h00, rd);
    wb_access(1'b1, 16'h0001, 8'h00, rd);
    gen_kind = 0; ramp_v = 8'h40; sq_active = 1'b1;
    repeat (5) tick();
    sq_active = 1'b0;
    tick();
    sq_active = 1'b1;
    first = ramp_v;
    repeat (9) tick();
    exp_w = '0;
    for (int i = 0; i < BYTES; i++) exp_w[8*i +: 8] = first + 8'(i);
    check("resume_word", sample, exp_w);
    check("resume_avail", SW'(sample_avail), SW'(1'b1));

    // DIV write mid-word restarts the pack; next pulse 18 cycles after ack
    wb_access(1'b1, 16'h0001, 8'h02, rd);
    gen_kind = 2;
    repeat (4) tick();
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 16'h0000; wb_dat_i = 8'h01;
    tick();
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (sample_avail === 1'b1) break;
    end
    check("pulse_gap", SW'(n), SW'(18));
    wb_access(1'b0, 16'h0000, 8'h00, rd);
    check("rd_div1", SW'(rd), SW'(8'h01));
    wb_access(1'b0, 16'h0001, 8'h00, rd);
    check("rd_mode2", SW'(rd), SW'(8'h02));
    wb_access(1'b1, 16'h0001, 8'hfe, rd);
    wb_access(1'b0, 16'h0001, 8'h00, rd);
    check("rd_mode_hi0", SW'(rd), SW'(8'h02));
    wb_access(1'b1, 16'h0005, 8'haa, rd);
    wb_access(1'b0, 16'h0005, 8'h00, rd);
    check("rd_unmapped", SW'(rd), SW'(8'h00));

    // asynchronous reset while a pulse is showing
    wb_access(1'b1, 16'h0000, 8'h00, rd);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (sample_avail === 1'b1) break;
    end
    check("pre_rst_avail", SW'(sample_avail), SW'(1'b1));
    rst = 1'b1;
    #1;
    check("async_avail", SW'(sample_avail), '0);
    check("async_sample", sample, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sq_active = 1'b0;
    model_reset();
    wb_access(1'b0, 16'h0000, 8'h00, rd);
    check("rst_div", SW'(rd), '0);
    wb_access(1'b0, 16'h0001, 8'h00, rd);
    check("rst_mode", SW'(rd), '0);

    // randomized traffic
    gen_kind = 2;
    for (int i = 0; i < 3000; i++) begin
      if (wb_stb_i) begin
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      end else if ($urandom_range(0, 99) < 3) begin
        wb_stb_i = 1'b1;
        wb_cyc_i = ($urandom_range(0, 7) != 0);
        wb_we_i  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       wb_adr_i = 16'h0000;
          1:       wb_adr_i = 16'h0001;
          2:       wb_adr_i = 16'h0005;
          default: wb_adr_i = 16'h0100;
        endcase
        wb_dat_i = (wb_adr_i == 16'h0000) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      end
      sq_active = ($urandom_range(0, 99) < 97);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
